// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, STOP_BITS stop bits, paced by baudTick.
// tx falls one clk after an accepted txStart; txStart is dropped (not queued) while txReady=0.
module uart_transmitter #(
  parameter int DATA_WIDTH = 8,
  parameter int RESOLUTION = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baudTick,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  txStart,
  output logic                  txReady,
  output logic                  txDone,
  output logic                  tx
);

  localparam int TW = $clog2(RESOLUTION * STOP_BITS);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [TW-1:0] BIT_LAST_TICK  = TW'(RESOLUTION - 1);
  localparam logic [TW-1:0] STOP_LAST_TICK = TW'(STOP_BITS * RESOLUTION - 1);
  localparam logic [BW-1:0] LAST_BIT       = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_nxt;
  logic [TW-1:0]         tick_cnt, tick_nxt;
  logic [BW-1:0]         bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic                  tx_nxt, ready_nxt, done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      txReady  <= 1'b1;
      txDone   <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
      txReady  <= ready_nxt;
      txDone   <= done_nxt;
    end
  end

  // tx/txReady are computed one state ahead so every output leaves a flop.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    tx_nxt    = tx;
    ready_nxt = txReady;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        tx_nxt    = 1'b1;
        ready_nxt = 1'b1;
        if (txStart) begin
          shift_nxt = dataIn;
          tick_nxt  = '0;
          state_nxt = START;
          tx_nxt    = 1'b0;
          ready_nxt = 1'b0;
        end
      end
      START: begin
        if (baudTick) begin
          if (tick_cnt == BIT_LAST_TICK) begin
            tick_nxt  = '0;
            bit_nxt   = '0;
            state_nxt = DATA;
            tx_nxt    = shift[0];
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (baudTick) begin
          if (tick_cnt == BIT_LAST_TICK) begin
            tick_nxt  = '0;
            shift_nxt = shift >> 1;
            if (bit_cnt == LAST_BIT) begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
            end else begin
              bit_nxt = bit_cnt + BW'(1);
              tx_nxt  = shift[1];
            end
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (baudTick) begin
          if (tick_cnt == STOP_LAST_TICK) begin
            tick_nxt  = '0;
            state_nxt = IDLE;
            ready_nxt = 1'b1;
            done_nxt  = 1'b1;
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        ready_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: default instance (8N1) and a 7-bit / 2-stop instance,
// frames checked by counting baudTicks against an ideal bit-sequence model.
module tb_uart_transmitter;

  localparam int R = 16;
  localparam int P = 27;

  logic       clk, rst, baudTick, tick_en;
  logic [7:0] data_a;
  logic       start_a, rdy_a, done_a, tx_a;
  logic [6:0] data_b;
  logic       start_b, rdy_b, done_b, tx_b;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  uart_transmitter dut_a (
    .clk(clk), .rst(rst), .baudTick(baudTick), .dataIn(data_a),
    .txStart(start_a), .txReady(rdy_a), .txDone(done_a), .tx(tx_a)
  );

  uart_transmitter #(.DATA_WIDTH(7), .RESOLUTION(R), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .baudTick(baudTick), .dataIn(data_b),
    .txStart(start_b), .txReady(rdy_b), .txDone(done_b), .tx(tx_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One tick every P clocks, driven on the falling edge; tick_en gates it for stall tests.
  initial begin
    int c = 0;
    baudTick = 1'b0;
    forever begin
      @(negedge clk);
      c = (c == P - 1) ? 0 : c + 1;
      baudTick = tick_en && (c == 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done_a === 1'b1) done_cnt_a++;
      if (done_b === 1'b1) done_cnt_b++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic logic tx_of(input bit b);
    return b ? tx_b : tx_a;
  endfunction
  function automatic logic rdy_of(input bit b);
    return b ? rdy_b : rdy_a;
  endfunction
  function automatic logic done_of(input bit b);
    return b ? done_b : done_a;
  endfunction

  // Ideal line level for bit slot k of a frame: start, data LSB first, then stop bits.
  function automatic int exp_bit(input logic [8:0] d, input int k, input int dw);
    if (k == 0) return 0;
    if (k <= dw) return int'(d[k-1]);
    return 1;
  endfunction

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Called just after a posedge. Sends d on instance b and checks the whole frame.
  task automatic send_frame(input bit b, input logic [8:0] d, input bit hold,
                            input int abort_at, input int stall_at, input int busy_at);
    int   dw = b ? 7 : 8;
    int   sb = b ? 2 : 1;
    int   total = (1 + dw + sb) * R;
    int   budget = total * P + 200;
    int   n = 0;
    int   cyc = 0;
    int   stop_hi = 0;
    bit   ticked;
    bit   early_done = 1'b0;
    bit   ready_seen = 1'b0;
    bit   busy_on = 1'b0;
    bit   stall_chg = 1'b0;
    logic stall_tx;
    if (b) begin data_b = d[6:0]; start_b = 1'b1; end
    else begin data_a = d[7:0]; start_a = 1'b1; end
    @(posedge clk);
    #1;
    check("accept_tx", tx_of(b), 0);
    check("accept_rdy", rdy_of(b), 0);
    if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
    while (n < total && cyc < budget) begin
      @(posedge clk);
      cyc++;
      ticked = baudTick;
      if (ticked) n++;
      #1;
      if (busy_on) begin start_a = 1'b0; busy_on = 1'b0; end
      if (n < total) begin
        if (done_of(b)) early_done = 1'b1;
        if (rdy_of(b)) ready_seen = 1'b1;
      end
      if (ticked) begin
        if (n % R == R / 2)
          check($sformatf("bit%0d", n / R), tx_of(b), exp_bit(d, n / R, dw));
        if (n > (1 + dw) * R && tx_of(b)) stop_hi++;
        if (n == abort_at) begin
          rst = 1'b1;
          #1;
          check("rst_tx", tx_of(b), 1);
          check("rst_rdy", rdy_of(b), 1);
          check("rst_done", done_of(b), 0);
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        if (n == busy_at) begin
          data_a  = 8'h3C;
          start_a = 1'b1;
          busy_on = 1'b1;
        end
        if (n == stall_at) begin
          tick_en  = 1'b0;
          stall_tx = tx_of(b);
          repeat (500) begin
            @(posedge clk);
            #1;
            if (tx_of(b) !== stall_tx || rdy_of(b) || done_of(b)) stall_chg = 1'b1;
          end
          check("stall_hold", stall_chg, 0);
          tick_en = 1'b1;
        end
      end
    end
    if (n < total) begin
      check("done_timeout", n, total);
    end else begin
      check("done_at_last_tick", done_of(b), 1);
      check("ready_at_end", rdy_of(b), 1);
      check("no_early_done", early_done, 0);
      check("busy_ready_low", ready_seen, 0);
      check("stop_ticks", stop_hi, sb * R);
      if (!hold) begin
        @(posedge clk);
        #1;
        check("done_one_clk", done_of(b), 0);
      end
    end
  endtask

  initial begin
    int  d0;
    bit  bad;
    rst = 1'b1; tick_en = 1'b1;
    start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_a", tx_a, 1);
    check("reset_rdy_a", rdy_a, 1);
    check("reset_done_a", done_a, 0);
    check("reset_tx_b", tx_b, 1);
    check("reset_rdy_b", rdy_b, 1);
    check("reset_done_b", done_b, 0);
    rst = 1'b0;
    idle(5);

    // Single frame 0xA5
    d0 = done_cnt_a;
    send_frame(1'b0, 9'h0A5, 1'b0, -1, -1, -1);
    check("a5_done_count", done_cnt_a - d0, 1);

    // Reset in the middle of a data bit, then a normal frame
    idle($urandom_range(0, 40));
    send_frame(1'b0, 9'($urandom_range(0, 255)), 1'b0, 3 * R + 5, -1, -1);
    idle($urandom_range(1, 40));
    send_frame(1'b0, 9'($urandom_range(0, 255)), 1'b0, -1, -1, -1);

    // Back-to-back with txStart held high
    idle($urandom_range(0, 40));
    d0 = done_cnt_a;
    send_frame(1'b0, 9'h000, 1'b1, -1, -1, -1);
    send_frame(1'b0, 9'h0FF, 1'b0, -1, -1, -1);
    check("b2b_done_count", done_cnt_a - d0, 2);

    // Start request while busy must be dropped
    idle($urandom_range(0, 40));
    d0 = done_cnt_a;
    send_frame(1'b0, 9'h081, 1'b0, -1, -1, 2 * R + $urandom_range(1, 4 * R));
    bad = 1'b0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (!tx_a || !rdy_a) bad = 1'b1;
    end
    check("busy_no_queue", bad, 0);
    check("busy_done_count", done_cnt_a - d0, 1);

    // baudTick stall during DATA
    idle($urandom_range(0, 40));
    send_frame(1'b0, 9'($urandom_range(0, 255)), 1'b0, -1,
               R * $urandom_range(2, 7) + $urandom_range(1, R - 1), -1);

    for (int i = 0; i < 3; i++) begin
      idle($urandom_range(0, 60));
      send_frame(1'b0, 9'($urandom_range(0, 255)), 1'b0, -1, -1, -1);
    end

    // 7 data bits, 2 stop bits
    idle($urandom_range(0, 40));
    d0 = done_cnt_b;
    send_frame(1'b1, 9'h055, 1'b0, -1, -1, -1);
    for (int i = 0; i < 2; i++) begin
      idle($urandom_range(0, 60));
      send_frame(1'b1, 9'($urandom_range(0, 127)), 1'b0, -1, -1, -1);
    end
    check("b_done_count", done_cnt_b - d0, 3);
    check("a_idle_during_b", done_cnt_a, 9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
